// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and word geometry.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ADDR_LSB   = 2;
  localparam int unsigned CNT_W      = 4;

endpackage

// File: rtl/dmem_array.sv
// Word storage with per-byte write enables and a combinational read port; never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] wstrb,
  input  logic [AW-1:0]         idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned j = 0; j < WORD_BYTES; j++) begin
        if (wstrb[j]) mem[idx][8*j +: 8] <= wdata[8*j +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: accepts one request, waits WAIT_CYCLES, performs the word
// access with range/alignment checking, then holds the response until taken.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned      AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0]      SPAN     = 33'(DEPTH_WORDS) << ADDR_LSB;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             do_access;

  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wstrb;

  logic        use_live;
  logic        acc_write;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_wstrb;
  logic [32:0] off;
  logic        acc_err;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] rdata_q;
  logic        err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    do_access  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            do_access  = 1'b1;
            state_next = RESP;
          end else begin
            cnt_next   = CNT_INIT;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          do_access  = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
    end else if (state == IDLE && req_valid) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_wstrb <= req_wstrb;
    end
  end

  // With no wait state the access happens on the accepting edge, so it must use
  // the live request rather than the (not yet loaded) latch.
  assign use_live  = (WAIT_CYCLES == 0) && (state == IDLE);
  assign acc_write = use_live ? req_write : lat_write;
  assign acc_addr  = use_live ? req_addr  : lat_addr;
  assign acc_wdata = use_live ? req_wdata : lat_wdata;
  assign acc_wstrb = use_live ? req_wstrb : lat_wstrb;

  // 33-bit offset: addresses below BASE_ADDR come out >= SPAN instead of wrapping.
  assign off     = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
  assign acc_err = (acc_addr[ADDR_LSB-1:0] != '0) || (off >= SPAN);
  assign mem_we  = do_access && acc_write && !acc_err && reset_n;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .wstrb (acc_wstrb),
    .idx   (off[AW+ADDR_LSB-1:ADDR_LSB]),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (do_access) begin
      rdata_q <= (acc_write || acc_err) ? '0 : mem_rdata;
      err_q   <= acc_err;
    end else if (state == RESP && rsp_ready) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: index 0 is the default WAIT_CYCLES=2 build, index 1 a WAIT_CYCLES=0 build.
module tb_dmem_responder;

  logic        clk;
  logic        reset_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wstrb [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int n_cmp = 0;
  int n_bad = 0;

  dmem_responder #(
    .DEPTH_WORDS (256),
    .WAIT_CYCLES (2),
    .BASE_ADDR   (32'h0000_0000)
  ) dut0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid[0]),
    .req_ready (req_ready[0]),
    .req_write (req_write[0]),
    .req_addr  (req_addr[0]),
    .req_wdata (req_wdata[0]),
    .req_wstrb (req_wstrb[0]),
    .rsp_valid (rsp_valid[0]),
    .rsp_ready (rsp_ready[0]),
    .rsp_rdata (rsp_rdata[0]),
    .rsp_err   (rsp_err[0])
  );

  dmem_responder #(
    .DEPTH_WORDS (256),
    .WAIT_CYCLES (0),
    .BASE_ADDR   (32'h0000_0000)
  ) dut1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid[1]),
    .req_ready (req_ready[1]),
    .req_write (req_write[1]),
    .req_addr  (req_addr[1]),
    .req_wdata (req_wdata[1]),
    .req_wstrb (req_wstrb[1]),
    .rsp_valid (rsp_valid[1]),
    .rsp_ready (rsp_ready[1]),
    .rsp_rdata (rsp_rdata[1]),
    .rsp_err   (rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction; 'hold' cycles of rsp_ready=0 back-pressure before the handshake.
  task automatic xfer(input int d, input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] ws, input int hold,
                      input logic [31:0] exp_rd, input logic exp_err);
    int          lat;
    logic [31:0] rd0;
    @(posedge clk); #1;
    chk({tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_write[d] = w;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_wstrb[d] = ws;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    req_write[d] = ~w;
    req_addr[d]  = 32'hFFFF_FFFF;
    req_wdata[d] = ~wd;
    req_wstrb[d] = 4'hF;
    lat = 1;
    while (!rsp_valid[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), (d == 0) ? 32'd3 : 32'd1);
    chk({tag, "_rdata"}, rsp_rdata[d], exp_rd);
    chk({tag, "_err"}, 32'(rsp_err[d]), 32'(exp_err));
    rd0 = rsp_rdata[d];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(rsp_valid[d]), 32'd1);
      chk({tag, "_hold_rdata"}, rsp_rdata[d], rd0);
      chk({tag, "_hold_req_ready"}, 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    chk({tag, "_post_valid"}, 32'(rsp_valid[d]), 32'd0);
    chk({tag, "_post_req_ready"}, 32'(req_ready[d]), 32'd1);
    chk({tag, "_post_rdata"}, rsp_rdata[d], 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_write[d] = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      req_wstrb[d] = '0;
      rsp_ready[d] = 1'b0;
    end
    #3;
    chk("rst_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_rdata", rsp_rdata[0], 32'd0);
    chk("rst_err", 32'(rsp_err[0]), 32'd0);
    #14 reset_n = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready[0]), 32'd1);
    chk("rst_req_ready_w0", 32'(req_ready[1]), 32'd1);

    xfer(0, "st_full",   1'b1, 32'h10,  32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0);
    xfer(0, "ld_full",   1'b0, 32'h10,  32'h0,         4'h0, 0, 32'hDEAD_BEEF, 1'b0);
    xfer(0, "st_byte0",  1'b1, 32'h10,  32'h0000_00AA, 4'h1, 0, 32'h0, 1'b0);
    xfer(0, "ld_byte0",  1'b0, 32'h10,  32'h0,         4'h0, 0, 32'hDEAD_BEAA, 1'b0);
    xfer(0, "st_lane2",  1'b1, 32'h10,  32'h0077_0000, 4'h4, 0, 32'h0, 1'b0);
    xfer(0, "ld_lane2",  1'b0, 32'h10,  32'h0,         4'h0, 0, 32'hDE77_BEAA, 1'b0);
    xfer(0, "st_nostrb", 1'b1, 32'h10,  32'h1111_1111, 4'h0, 0, 32'h0, 1'b0);
    xfer(0, "ld_nostrb", 1'b0, 32'h10,  32'h0,         4'h0, 0, 32'hDE77_BEAA, 1'b0);
    xfer(0, "ld_misal",  1'b0, 32'h13,  32'h0,         4'h0, 0, 32'h0, 1'b1);
    xfer(0, "ld_oor",    1'b0, 32'h400, 32'h0,         4'h0, 0, 32'h0, 1'b1);
    xfer(0, "st_oor",    1'b1, 32'h410, 32'h5555_5555, 4'hF, 0, 32'h0, 1'b1);
    xfer(0, "st_misal",  1'b1, 32'h12,  32'h9999_9999, 4'hF, 0, 32'h0, 1'b1);
    xfer(0, "ld_after_err", 1'b0, 32'h10, 32'h0,       4'h0, 0, 32'hDE77_BEAA, 1'b0);
    xfer(0, "st_last",   1'b1, 32'h3FC, 32'h1122_3344, 4'hF, 0, 32'h0, 1'b0);
    xfer(0, "ld_last",   1'b0, 32'h3FC, 32'h0,         4'h0, 0, 32'h1122_3344, 1'b0);
    xfer(0, "ld_stall",  1'b0, 32'h10,  32'h0,         4'h0, 5, 32'hDE77_BEAA, 1'b0);

    // Abandon a store in WAIT with an asynchronous reset.
    xfer(0, "st_pre20",  1'b1, 32'h20,  32'hCAFE_F00D, 4'hF, 0, 32'h0, 1'b0);
    @(posedge clk); #1;
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h20;
    req_wdata[0] = 32'h1234_5678;
    req_wstrb[0] = 4'hF;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("mid_in_wait", 32'(req_ready[0]), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid[0]), 32'd0);
    chk("mid_rst_rdata", rsp_rdata[0], 32'd0);
    chk("mid_rst_err", 32'(rsp_err[0]), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_valid", 32'(rsp_valid[0]), 32'd0);
    chk("mid_rel_req_ready", 32'(req_ready[0]), 32'd1);
    xfer(0, "ld_20", 1'b0, 32'h20, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b0);

    xfer(1, "w0_st",  1'b1, 32'h40,  32'h55AA_33CC, 4'hF, 0, 32'h0, 1'b0);
    xfer(1, "w0_ld",  1'b0, 32'h40,  32'h0,         4'h0, 0, 32'h55AA_33CC, 1'b0);
    xfer(1, "w0_err", 1'b0, 32'h401, 32'h0,         4'h0, 2, 32'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory target that serves CPU load/store requests over a valid/ready request/response handshake.
- Sits on the data side of the core, in place of a zero-latency memory.
- Responder to the core's data port: accepts one request, waits a configurable number of cycles, performs the word access, then holds a response until the initiator takes it.
- Flags misaligned and out-of-range accesses with an error response instead of touching storage.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words of storage (power of two, ≥4).
- WAIT_CYCLES, 2, extra cycles between request acceptance and response (0..15).
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (word aligned).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_wstrb  in  4  store byte enables; bit i enables byte lane i (bits 8i+7:8i). Ignored for loads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  initiator accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  access was misaligned or out of range.

Behaviour:
- Reset (reset_n low, asynchronous):
  - FSM goes to IDLE; req_ready=1 after release; rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - Storage contents are not cleared.
  - Reset asserted mid-transaction abandons it: a pending store is discarded (never written), and no response is issued.
- States: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid, latch write, addr, wdata and wstrb.
    - WAIT_CYCLES>0: load counter with WAIT_CYCLES-1 and go to WAIT.
    - WAIT_CYCLES=0: go straight to the access step.
  - WAIT: req_ready=0. Decrement the counter. When it reaches 0, do the access and go to RESP.
  - RESP: rsp_valid=1; rsp_rdata and rsp_err hold stable until the handshake. When rsp_ready=1, go to IDLE.
- Access step, performed on the edge that enters RESP:
  - Error check: err = (addr[1:0]≠0) OR addr<BASE_ADDR OR addr≥BASE_ADDR+4*DEPTH_WORDS. Compute addr−BASE_ADDR in 33 bits, so the comparison has no wrap-around.
  - Word index = (addr−BASE_ADDR)>>2.
  - Store, no error: write the enabled byte lanes. wstrb=0 is a legal no-op (err=0). rdata=0.
  - Load, no error: rdata = stored word.
  - Error: no storage update; rdata=0, err=1.
- Latency:
  - Request accepted on edge T; rsp_valid=1 from edge T+1+WAIT_CYCLES.
  - Minimum initiation interval is WAIT_CYCLES+2 cycles, because req_ready is low outside IDLE.
- Stalls and ordering:
  - Response back-pressure: rsp_ready low holds RESP indefinitely; outputs stay constant.
  - Back-to-back requests are strictly in order.
  - A load issued after a store to the same word returns the stored value.
- Outputs in IDLE/WAIT: rsp_valid=0, rsp_rdata=0, rsp_err=0.
- req_* inputs are sampled only on the accepting edge; later changes have no effect on the transaction.

Decomposition:
- Shared package dmem_pkg holds:
  - state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - word-size constants (WORD_BYTES=4, ADDR_LSB=2);
  - width of the wait counter.
- Sub-module dmem_array holds the storage: DEPTH_WORDS×32 array, byte-enable write, combinational read, no reset.
- dmem_responder contains the FSM, counter, request latch, error check and response registers.

Test Plan:
- Store 0xDEADBEEF to 0x10 with wstrb=4'hF, then load 0x10 (WAIT_CYCLES=2) → each rsp_valid rises 3 cycles after acceptance; load returns 0xDEADBEEF, err=0.
- Store 0x000000AA to 0x10 with wstrb=4'b0001 over 0xDEADBEEF, then load → rdata=0xDEADBEAA.
- Load from 0x13 and from BASE_ADDR+4*DEPTH_WORDS (0x400) → err=1, rdata=0; a subsequent load of 0x10 is unchanged.
- Hold rsp_ready=0 for 5 cycles during RESP → rsp_valid and rsp_rdata stable, req_ready=0; the response completes on the first cycle rsp_ready=1, and req_ready=1 the next cycle.
- Assert reset_n=0 while a store of 0x12345678 to 0x20 is in WAIT → outputs 0 immediately; after release, a load of 0x20 returns its pre-store value.
- WAIT_CYCLES=0 build: load accepted at edge T → rsp_valid at edge T+1 with correct data.
